// File: rtl/tlul_burst_sequencer.sv
// TL-UL burst sequencer: expands Get/Put bursts into one scratchpad beat per 8-byte address
// and hides the surplus per-beat Put acks. Define TLUL_BURST_SEQ_CHECK_EN to compile protocol assertions.
module tlul_burst_sequencer #(
   parameter int TL_AW     = 32,
   parameter int TL_DW     = 64,
   parameter int TL_SZW    = 3,
   parameter int TL_AIW    = 8,
   parameter int MAX_SIZE  = 6,
   parameter int TAG_DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [2:0]                 up_a_opcode,
   input  logic [2:0]                 up_a_param,
   input  logic [TL_SZW-1:0]          up_a_size,
   input  logic [TL_AIW-1:0]          up_a_source,
   input  logic [TL_AW-1:0]           up_a_address,
   input  logic [7:0]                 up_a_mask,
   input  logic [TL_DW-1:0]           up_a_data,
   input  logic                       up_a_valid,
   output logic                       up_a_ready,
   output logic [2:0]                 dn_a_opcode,
   output logic [2:0]                 dn_a_param,
   output logic [TL_SZW-1:0]          dn_a_size,
   output logic [TL_AIW-1:0]          dn_a_source,
   output logic [TL_AW-1:0]           dn_a_address,
   output logic [7:0]                 dn_a_mask,
   output logic [TL_DW-1:0]           dn_a_data,
   output logic                       dn_a_valid,
   input  logic                       dn_a_ready,
   input  logic [2:0]                 dn_d_opcode,
   input  logic [2:0]                 dn_d_param,
   input  logic [TL_SZW-1:0]          dn_d_size,
   input  logic [TL_AIW-1:0]          dn_d_source,
   input  logic                       dn_d_sink,
   input  logic                       dn_d_denied,
   input  logic [TL_DW-1:0]           dn_d_data,
   input  logic                       dn_d_corrupt,
   input  logic                       dn_d_valid,
   output logic                       dn_d_ready,
   output logic [2:0]                 up_d_opcode,
   output logic [2:0]                 up_d_param,
   output logic [TL_SZW-1:0]          up_d_size,
   output logic [TL_AIW-1:0]          up_d_source,
   output logic                       up_d_sink,
   output logic                       up_d_denied,
   output logic [TL_DW-1:0]           up_d_data,
   output logic                       up_d_corrupt,
   output logic                       up_d_valid,
   input  logic                       up_d_ready,
   output logic [1:0]                 dbg_state,
   output logic [$clog2(TAG_DEPTH):0] dbg_tag_cnt
);

   // Valid/ready: a transfer happens on a cycle where valid & ready are both high at the clock
   // edge; a producer never withdraws or alters a beat while valid & !ready.

   typedef enum logic [1:0] {IDLE = 2'd0, GET_BURST = 2'd1, PUT_BURST = 2'd2} state_t;

   localparam int CW = (MAX_SIZE > 4) ? MAX_SIZE - 3 : 1;
   localparam int PW = $clog2(TAG_DEPTH);
   localparam logic [2:0] OP_GET      = 3'd4;
   localparam logic [2:0] OP_PUT_FULL = 3'd0;
   localparam logic [2:0] OP_PUT_PART = 3'd1;

   state_t              state;
   logic [CW-1:0]       cnt;
   logic [CW-1:0]       lat_beats_m1;
   logic [TL_AW-1:0]    lat_addr;
   logic [TL_SZW-1:0]   lat_size;
   logic [TL_AIW-1:0]   lat_source;
   logic [2:0]          lat_param;

   logic [TAG_DEPTH-1:0] tag_mem;
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [PW:0]          tag_cnt;
   logic                 tag_full;
   logic                 tag_empty;

   logic                is_get;
   logic                is_put;
   logic                size_ok;
   logic                aligned;
   logic                expandable;
   logic [TL_AW-1:0]    align_mask;
   logic [TL_SZW-1:0]   up_shift;
   logic [CW:0]         up_beats;
   logic [CW-1:0]       up_beats_m1;
   logic [TL_AW-1:0]    beat_addr;
   logic                push_drop;
   logic                dn_hs;
   logic                drop;
   logic                pop;

   assign is_get      = (up_a_opcode == OP_GET);
   assign is_put      = (up_a_opcode == OP_PUT_FULL) || (up_a_opcode == OP_PUT_PART);
   assign size_ok     = (up_a_size > TL_SZW'(3)) && (int'(up_a_size) <= MAX_SIZE);
   assign align_mask  = ~({TL_AW{1'b1}} << up_a_size);
   assign aligned     = (up_a_address & align_mask) == '0;
   assign expandable  = (is_get || is_put) && size_ok && aligned;
   // Beat count minus one; only meaningful when the request is expandable.
   assign up_shift    = up_a_size - TL_SZW'(3);
   assign up_beats    = (CW+1)'(1) << up_shift;
   assign up_beats_m1 = CW'(up_beats - (CW+1)'(1));
   assign beat_addr   = lat_addr | (TL_AW'(cnt) << 3);

   assign tag_full  = (tag_cnt == (PW+1)'(TAG_DEPTH));
   assign tag_empty = (tag_cnt == '0);

   always_comb begin
      dn_a_opcode  = up_a_opcode;
      dn_a_param   = up_a_param;
      dn_a_size    = up_a_size;
      dn_a_source  = up_a_source;
      dn_a_address = up_a_address;
      dn_a_mask    = up_a_mask;
      dn_a_data    = up_a_data;
      dn_a_valid   = up_a_valid & ~tag_full;
      up_a_ready   = dn_a_ready & ~tag_full;
      push_drop    = is_put & expandable;
      case (state)
         GET_BURST: begin
            dn_a_opcode  = OP_GET;
            dn_a_param   = lat_param;
            dn_a_size    = lat_size;
            dn_a_source  = lat_source;
            dn_a_address = beat_addr;
            dn_a_mask    = 8'hFF;
            dn_a_data    = '0;
            dn_a_valid   = ~tag_full;
            up_a_ready   = 1'b0;
            push_drop    = 1'b0;
         end
         PUT_BURST: begin
            dn_a_size    = lat_size;
            dn_a_source  = lat_source;
            dn_a_address = beat_addr;
            push_drop    = (cnt != lat_beats_m1);
         end
         default: ;
      endcase
   end

   assign dn_hs = dn_a_valid & dn_a_ready;

   // A D beat with no tag outstanding is forwarded rather than dropped.
   assign drop         = ~tag_empty & tag_mem[rd_ptr];
   assign up_d_opcode  = dn_d_opcode;
   assign up_d_param   = dn_d_param;
   assign up_d_size    = dn_d_size;
   assign up_d_source  = dn_d_source;
   assign up_d_sink    = dn_d_sink;
   assign up_d_denied  = dn_d_denied;
   assign up_d_data    = dn_d_data;
   assign up_d_corrupt = dn_d_corrupt;
   assign up_d_valid   = dn_d_valid & ~drop;
   assign dn_d_ready   = drop | up_d_ready;
   assign pop          = dn_d_valid & dn_d_ready & ~tag_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_mem <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         tag_cnt <= '0;
      end else begin
         if (dn_hs) begin
            tag_mem[wr_ptr] <= push_drop;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({dn_hs, pop})
            2'b10:   tag_cnt <= tag_cnt + 1'b1;
            2'b01:   tag_cnt <= tag_cnt - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         lat_beats_m1 <= '0;
         lat_addr     <= '0;
         lat_size     <= '0;
         lat_source   <= '0;
         lat_param    <= '0;
      end else begin
         case (state)
            IDLE: begin
               // In IDLE the downstream handshake is the upstream acceptance.
               if (dn_hs && expandable) begin
                  lat_addr     <= up_a_address;
                  lat_size     <= up_a_size;
                  lat_source   <= up_a_source;
                  lat_param    <= up_a_param;
                  lat_beats_m1 <= up_beats_m1;
                  cnt          <= CW'(1);
                  state        <= is_get ? GET_BURST : PUT_BURST;
               end
            end
            GET_BURST, PUT_BURST: begin
               if (dn_hs) begin
                  if (cnt == lat_beats_m1) begin
                     cnt   <= '0;
                     state <= IDLE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign dbg_state   = state;
   assign dbg_tag_cnt = tag_cnt;

`ifdef TLUL_BURST_SEQ_CHECK_EN
   logic [2:0] lat_opcode;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lat_opcode <= '0;
      else if (state == IDLE && dn_hs && expandable) lat_opcode <= up_a_opcode;
   end

   a_up_stable: assert property (@(posedge clk) disable iff (rst)
      (up_a_valid && !up_a_ready) |=> (up_a_valid && $stable(up_a_opcode) && $stable(up_a_param) &&
      $stable(up_a_size) && $stable(up_a_source) && $stable(up_a_address) &&
      $stable(up_a_mask) && $stable(up_a_data)))
      else $error("upstream A beat changed while stalled");

   a_tag_overflow: assert property (@(posedge clk) disable iff (rst)
      !(dn_hs && tag_full && !pop))
      else $error("tag FIFO overflow");

   a_tag_underflow: assert property (@(posedge clk) disable iff (rst)
      !(pop && tag_empty))
      else $error("tag FIFO underflow");

   a_put_fields: assert property (@(posedge clk) disable iff (rst)
      (state == PUT_BURST && up_a_valid) |-> (up_a_opcode == lat_opcode && up_a_source == lat_source))
      else $error("opcode or source changed inside a Put burst");
`endif

endmodule

// File: tb/tb_tlul_burst_sequencer.sv
// Directed bench for tlul_burst_sequencer: a vector table for single-cycle A-channel behaviour
// plus hand-written burst, backpressure, tag-full and reset sequences against a scratchpad model.
module tb_tlul_burst_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  up_a_opcode, up_a_param;
   logic [2:0]  up_a_size;
   logic [7:0]  up_a_source;
   logic [31:0] up_a_address;
   logic [7:0]  up_a_mask;
   logic [63:0] up_a_data;
   logic        up_a_valid, up_a_ready;
   logic [2:0]  dn_a_opcode, dn_a_param;
   logic [2:0]  dn_a_size;
   logic [7:0]  dn_a_source;
   logic [31:0] dn_a_address;
   logic [7:0]  dn_a_mask;
   logic [63:0] dn_a_data;
   logic        dn_a_valid, dn_a_ready;
   logic [2:0]  dn_d_opcode, dn_d_param, dn_d_size;
   logic [7:0]  dn_d_source;
   logic        dn_d_sink, dn_d_denied, dn_d_corrupt, dn_d_valid, dn_d_ready;
   logic [63:0] dn_d_data;
   logic [2:0]  up_d_opcode, up_d_param, up_d_size;
   logic [7:0]  up_d_source;
   logic        up_d_sink, up_d_denied, up_d_corrupt, up_d_valid, up_d_ready;
   logic [63:0] up_d_data;
   logic [1:0]  dbg_state;
   logic [4:0]  dbg_tag_cnt;

   always #5 clk = ~clk;

   tlul_burst_sequencer dut (
      .clk(clk), .rst(rst),
      .up_a_opcode(up_a_opcode), .up_a_param(up_a_param), .up_a_size(up_a_size),
      .up_a_source(up_a_source), .up_a_address(up_a_address), .up_a_mask(up_a_mask),
      .up_a_data(up_a_data), .up_a_valid(up_a_valid), .up_a_ready(up_a_ready),
      .dn_a_opcode(dn_a_opcode), .dn_a_param(dn_a_param), .dn_a_size(dn_a_size),
      .dn_a_source(dn_a_source), .dn_a_address(dn_a_address), .dn_a_mask(dn_a_mask),
      .dn_a_data(dn_a_data), .dn_a_valid(dn_a_valid), .dn_a_ready(dn_a_ready),
      .dn_d_opcode(dn_d_opcode), .dn_d_param(dn_d_param), .dn_d_size(dn_d_size),
      .dn_d_source(dn_d_source), .dn_d_sink(dn_d_sink), .dn_d_denied(dn_d_denied),
      .dn_d_data(dn_d_data), .dn_d_corrupt(dn_d_corrupt), .dn_d_valid(dn_d_valid),
      .dn_d_ready(dn_d_ready),
      .up_d_opcode(up_d_opcode), .up_d_param(up_d_param), .up_d_size(up_d_size),
      .up_d_source(up_d_source), .up_d_sink(up_d_sink), .up_d_denied(up_d_denied),
      .up_d_data(up_d_data), .up_d_corrupt(up_d_corrupt), .up_d_valid(up_d_valid),
      .up_d_ready(up_d_ready),
      .dbg_state(dbg_state), .dbg_tag_cnt(dbg_tag_cnt)
   );

   typedef struct {
      logic [31:0] addr;
      logic [2:0]  opcode;
      logic [2:0]  size;
      logic [7:0]  mask;
      logic [7:0]  source;
      logic [63:0] data;
      int          cyc;
   } a_rec_t;

   typedef struct {
      logic [2:0]  opcode;
      logic [7:0]  source;
      logic [63:0] data;
   } d_rec_t;

   typedef struct {
      logic [2:0]  op;
      logic [2:0]  sz;
      logic [31:0] addr;
      logic        rdy;
      logic        exp_up_rdy;
      logic        exp_dn_valid;
      logic [31:0] exp_addr;
      logic [2:0]  exp_sz;
      logic [1:0]  exp_state;
   } vec_t;

   a_rec_t dn_log[$];
   d_rec_t up_log[$];
   d_rec_t resp_q[$];
   logic   resp_en = 1'b0;
   int     cyc = 0;
   int     checks = 0;
   int     errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Sampled on the falling edge: whatever is valid & ready here completes at the next rising edge.
   always @(negedge clk) begin
      if (rst) begin
         resp_q.delete();
      end else begin
         if (dn_d_valid && dn_d_ready && resp_q.size() > 0) void'(resp_q.pop_front());
         if (dn_a_valid && dn_a_ready) begin
            a_rec_t a;
            d_rec_t r;
            a.addr = dn_a_address; a.opcode = dn_a_opcode; a.size = dn_a_size;
            a.mask = dn_a_mask; a.source = dn_a_source; a.data = dn_a_data; a.cyc = cyc;
            dn_log.push_back(a);
            r.opcode = (dn_a_opcode == 3'd4) ? 3'd1 : 3'd0;
            r.source = dn_a_source;
            r.data   = {32'h0, dn_a_address};
            resp_q.push_back(r);
         end
         if (up_d_valid && up_d_ready) begin
            d_rec_t u;
            u.opcode = up_d_opcode; u.source = up_d_source; u.data = up_d_data;
            up_log.push_back(u);
         end
      end
   end

   // Scratchpad model: answers each accepted A beat in order, AccessAckData for Get, AccessAck otherwise.
   always @(posedge clk) begin
      #1;
      if (resp_en && resp_q.size() > 0) begin
         dn_d_valid  = 1'b1;
         dn_d_opcode = resp_q[0].opcode;
         dn_d_source = resp_q[0].source;
         dn_d_data   = resp_q[0].data;
      end else begin
         dn_d_valid  = 1'b0;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_a(input logic [2:0] op, input logic [2:0] sz, input logic [31:0] addr,
                         input logic [7:0] src, input logic [63:0] data);
      int t;
      t = 0;
      @(posedge clk); #1;
      up_a_opcode = op; up_a_param = 3'd0; up_a_size = sz; up_a_source = src;
      up_a_address = addr; up_a_mask = 8'hFF; up_a_data = data; up_a_valid = 1'b1;
      @(negedge clk);
      while (!up_a_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("send_a_accepted", {63'h0, up_a_ready}, 64'h1);
      @(posedge clk); #1;
      up_a_valid = 1'b0;
   endtask

   task automatic wait_up(input int n, input string name);
      int t;
      t = 0;
      while (up_log.size() < n && t < 400) begin
         @(negedge clk);
         t++;
      end
      repeat (4) @(negedge clk);
      chk(name, 64'(up_log.size()), 64'(n));
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      vec_t vecs[8];
      int   ab, db, t, beat;
      logic prev_stall, hs;
      logic [31:0] prev_addr;
      logic [63:0] prev_data;

      vecs[0] = '{3'd4, 3'd3, 32'h100, 1'b1, 1'b1, 1'b1, 32'h100, 3'd3, 2'd0};
      vecs[1] = '{3'd4, 3'd7, 32'h080, 1'b1, 1'b1, 1'b1, 32'h080, 3'd7, 2'd0};
      vecs[2] = '{3'd4, 3'd5, 32'h028, 1'b1, 1'b1, 1'b1, 32'h028, 3'd5, 2'd0};
      vecs[3] = '{3'd2, 3'd5, 32'h020, 1'b1, 1'b1, 1'b1, 32'h020, 3'd5, 2'd0};
      vecs[4] = '{3'd0, 3'd2, 32'h104, 1'b1, 1'b1, 1'b1, 32'h104, 3'd2, 2'd0};
      vecs[5] = '{3'd4, 3'd6, 32'h040, 1'b0, 1'b0, 1'b1, 32'h040, 3'd6, 2'd0};
      vecs[6] = '{3'd1, 3'd4, 32'h010, 1'b0, 1'b0, 1'b1, 32'h010, 3'd4, 2'd0};
      vecs[7] = '{3'd4, 3'd6, 32'h040, 1'b1, 1'b1, 1'b1, 32'h040, 3'd6, 2'd1};

      up_a_opcode = 0; up_a_param = 0; up_a_size = 0; up_a_source = 0; up_a_address = 0;
      up_a_mask = 0; up_a_data = 0; up_a_valid = 0; dn_a_ready = 1; up_d_ready = 1;
      dn_d_opcode = 0; dn_d_param = 0; dn_d_size = 0; dn_d_source = 0; dn_d_sink = 0;
      dn_d_denied = 0; dn_d_data = 0; dn_d_corrupt = 0; dn_d_valid = 0;

      // Reset values
      repeat (2) @(posedge clk); #1;
      chk("rst_state", 64'(dbg_state), 64'd0);
      chk("rst_tag_cnt", 64'(dbg_tag_cnt), 64'd0);
      chk("rst_dn_a_valid", 64'(dn_a_valid), 64'd0);
      chk("rst_up_d_valid", 64'(up_d_valid), 64'd0);
      chk("rst_up_a_ready_hi", 64'(up_a_ready), 64'd1);
      dn_a_ready = 1'b0; #1;
      chk("rst_up_a_ready_lo", 64'(up_a_ready), 64'd0);
      dn_a_ready = 1'b1;
      rst = 1'b0;

      // Vector table: IDLE forwarding, passthrough cases and burst entry
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         up_a_opcode = vecs[i].op; up_a_size = vecs[i].sz; up_a_address = vecs[i].addr;
         up_a_source = 8'(8'h10 + i); up_a_data = 64'(i); up_a_mask = 8'hFF;
         up_a_valid = 1'b1; dn_a_ready = vecs[i].rdy;
         #1;
         chk($sformatf("vec%0d_dn_valid", i), 64'(dn_a_valid), 64'(vecs[i].exp_dn_valid));
         chk($sformatf("vec%0d_up_ready", i), 64'(up_a_ready), 64'(vecs[i].exp_up_rdy));
         chk($sformatf("vec%0d_dn_addr", i), 64'(dn_a_address), 64'(vecs[i].exp_addr));
         chk($sformatf("vec%0d_dn_size", i), 64'(dn_a_size), 64'(vecs[i].exp_sz));
         chk($sformatf("vec%0d_dn_source", i), 64'(dn_a_source), 64'(8'h10 + i));
         @(posedge clk); #1;
         up_a_valid = 1'b0; dn_a_ready = 1'b1;
         chk($sformatf("vec%0d_state", i), 64'(dbg_state), 64'(vecs[i].exp_state));
      end
      rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("rst2_state", 64'(dbg_state), 64'd0);
      chk("rst2_tag_cnt", 64'(dbg_tag_cnt), 64'd0);
      rst = 1'b0;
      resp_en = 1'b1;

      // Single-beat Get
      ab = dn_log.size(); db = up_log.size();
      send_a(3'd4, 3'd3, 32'h100, 8'h05, 64'h0);
      wait_up(db + 1, "get1_up_count");
      chk("get1_dn_count", 64'(dn_log.size() - ab), 64'd1);
      if (dn_log.size() > ab) begin
         chk("get1_dn_addr", 64'(dn_log[ab].addr), 64'h100);
         chk("get1_dn_size", 64'(dn_log[ab].size), 64'd3);
      end
      if (up_log.size() > db) begin
         chk("get1_up_opcode", 64'(up_log[db].opcode), 64'd1);
         chk("get1_up_source", 64'(up_log[db].source), 64'h05);
         chk("get1_up_data", up_log[db].data, 64'h100);
      end

      // 8-beat Get burst
      ab = dn_log.size(); db = up_log.size();
      send_a(3'd4, 3'd6, 32'h40, 8'h22, 64'h0);
      wait_up(db + 8, "get8_up_count");
      chk("get8_dn_count", 64'(dn_log.size() - ab), 64'd8);
      chk("get8_state", 64'(dbg_state), 64'd0);
      if (dn_log.size() >= ab + 8 && up_log.size() >= db + 8) begin
         for (int i = 0; i < 8; i++) begin
            chk($sformatf("get8_dn_addr%0d", i), 64'(dn_log[ab+i].addr), 64'(32'h40 + 8*i));
            chk($sformatf("get8_dn_size%0d", i), 64'(dn_log[ab+i].size), 64'd6);
            chk($sformatf("get8_dn_mask%0d", i), 64'(dn_log[ab+i].mask), 64'hFF);
            chk($sformatf("get8_dn_op%0d", i), 64'(dn_log[ab+i].opcode), 64'd4);
            chk($sformatf("get8_dn_src%0d", i), 64'(dn_log[ab+i].source), 64'h22);
            chk($sformatf("get8_dn_cyc%0d", i), 64'(dn_log[ab+i].cyc - dn_log[ab].cyc), 64'(i));
            chk($sformatf("get8_up_data%0d", i), up_log[db+i].data, 64'(32'h40 + 8*i));
            chk($sformatf("get8_up_src%0d", i), 64'(up_log[db+i].source), 64'h22);
         end
      end

      // 4-beat PutFullData: three acks dropped, the last one forwarded
      ab = dn_log.size(); db = up_log.size();
      for (int b = 0; b < 4; b++) send_a(3'd0, 3'd5, 32'h20, 8'h33, 64'(64'hA0 + b));
      wait_up(db + 1, "put4_up_count");
      chk("put4_dn_count", 64'(dn_log.size() - ab), 64'd4);
      if (dn_log.size() >= ab + 4) begin
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("put4_dn_addr%0d", i), 64'(dn_log[ab+i].addr), 64'(32'h20 + 8*i));
            chk($sformatf("put4_dn_data%0d", i), dn_log[ab+i].data, 64'(64'hA0 + i));
            chk($sformatf("put4_dn_size%0d", i), 64'(dn_log[ab+i].size), 64'd5);
         end
      end
      if (up_log.size() > db) begin
         chk("put4_up_opcode", 64'(up_log[db].opcode), 64'd0);
         chk("put4_up_source", 64'(up_log[db].source), 64'h33);
         chk("put4_up_last_ack", up_log[db].data, 64'h38);
      end
      chk("put4_state", 64'(dbg_state), 64'd0);
      chk("put4_tags_drained", 64'(dbg_tag_cnt), 64'd0);

      // 8-beat PutPartialData with dn_a_ready toggling every cycle
      ab = dn_log.size(); db = up_log.size();
      @(posedge clk); #1;
      beat = 0; t = 0; prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
      up_a_opcode = 3'd1; up_a_size = 3'd6; up_a_source = 8'h44; up_a_address = 32'h80;
      up_a_mask = 8'hFF; up_a_data = 64'hD0; up_a_valid = 1'b1; dn_a_ready = 1'b1;
      while (beat < 8 && t < 200) begin
         @(negedge clk);
         if (prev_stall) begin
            chk("put8_stall_valid", 64'(dn_a_valid), 64'd1);
            chk("put8_stall_addr", 64'(dn_a_address), 64'(prev_addr));
            chk("put8_stall_data", dn_a_data, prev_data);
         end
         prev_stall = dn_a_valid && !dn_a_ready;
         prev_addr  = dn_a_address;
         prev_data  = dn_a_data;
         hs = up_a_valid && up_a_ready;
         @(posedge clk); #1;
         dn_a_ready = ~dn_a_ready;
         if (hs) begin
            beat++;
            if (beat < 8) up_a_data = 64'(64'hD0 + beat);
            else up_a_valid = 1'b0;
         end
         t++;
      end
      dn_a_ready = 1'b1;
      chk("put8_beats_sent", 64'(beat), 64'd8);
      wait_up(db + 1, "put8_up_count");
      chk("put8_dn_count", 64'(dn_log.size() - ab), 64'd8);
      if (dn_log.size() >= ab + 8) begin
         for (int i = 0; i < 8; i++) begin
            chk($sformatf("put8_dn_addr%0d", i), 64'(dn_log[ab+i].addr), 64'(32'h80 + 8*i));
            chk($sformatf("put8_dn_data%0d", i), dn_log[ab+i].data, 64'(64'hD0 + i));
         end
      end
      if (up_log.size() > db) begin
         chk("put8_up_source", 64'(up_log[db].source), 64'h44);
         chk("put8_up_last_ack", up_log[db].data, 64'hB8);
      end

      // Tag FIFO full: 16 Gets with up_d_ready low, a 17th must wait for a drain
      up_d_ready = 1'b0;
      ab = dn_log.size(); db = up_log.size();
      for (int i = 0; i < 16; i++) send_a(3'd4, 3'd3, 32'(32'h200 + 8*i), 8'h50, 64'h0);
      @(posedge clk); #1;
      chk("full_tag_cnt", 64'(dbg_tag_cnt), 64'd16);
      up_a_opcode = 3'd4; up_a_size = 3'd3; up_a_address = 32'h280; up_a_source = 8'h50;
      up_a_valid = 1'b1;
      #1;
      chk("full_dn_valid", 64'(dn_a_valid), 64'd0);
      chk("full_up_ready", 64'(up_a_ready), 64'd0);
      repeat (3) @(negedge clk);
      chk("full_dn_valid_held", 64'(dn_a_valid), 64'd0);
      chk("full_dn_count", 64'(dn_log.size() - ab), 64'd16);
      @(posedge clk); #1;
      up_d_ready = 1'b1;
      t = 0;
      @(negedge clk);
      while (!up_a_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("full_resume", 64'(up_a_ready), 64'd1);
      @(posedge clk); #1;
      up_a_valid = 1'b0;
      wait_up(db + 17, "full_up_count");
      if (up_log.size() >= db + 17) begin
         for (int i = 0; i < 17; i++)
            chk($sformatf("full_up_data%0d", i), up_log[db+i].data, 64'(32'h200 + 8*i));
      end
      chk("full_tags_drained", 64'(dbg_tag_cnt), 64'd0);

      // Reset while a Get burst is at beat 3 of 8
      resp_en = 1'b0;
      ab = dn_log.size();
      send_a(3'd4, 3'd6, 32'h40, 8'h66, 64'h0);
      @(posedge clk); @(posedge clk); #1;
      chk("midrst_pre_state", 64'(dbg_state), 64'd1);
      chk("midrst_pre_tags", 64'(dbg_tag_cnt), 64'd3);
      rst = 1'b1;
      #1;
      chk("midrst_state", 64'(dbg_state), 64'd0);
      chk("midrst_tags", 64'(dbg_tag_cnt), 64'd0);
      chk("midrst_dn_valid", 64'(dn_a_valid), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("midrst_no_more_beats", 64'(dn_log.size() - ab), 64'd3);
      chk("midrst_idle", 64'(dbg_state), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tlul_burst_sequencer.md
# tlul_burst_sequencer

Sits directly upstream of the scratchpad wrapper on the TL-UL slave path and turns multi-beat TileLink bursts into the single-beat-per-address requests the scratchpad RAM consumes. A Get burst is expanded into N address-incrementing beats. Put-burst beats are re-addressed. On the return path, the surplus per-beat AccessAcks of a Put burst are dropped, so the requester sees exactly one response per TileLink message. All signals are flat Verilog-friendly ports on both sides.

## Interface
- TL_AW, 32: address width
- TL_DW, 64: data width, fixed at 64 (beat = 8 bytes)
- TL_SZW, 3: size field width
- TL_AIW, 8: source width
- MAX_SIZE, 6: largest log2(bytes) expanded; max beats = 2^(MAX_SIZE-3)
- TAG_DEPTH, 16: outstanding downstream beats tracked (power of 2)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- up_a_opcode/param/size/source/address/mask/data/valid  in  3/3/TL_SZW/TL_AIW/TL_AW/8/TL_DW/1  upstream A channel
- up_a_ready  out  1  upstream A ready
- dn_a_opcode/param/size/source/address/mask/data/valid  out  same widths  A channel to scratchpad
- dn_a_ready  in  1  scratchpad A ready
- dn_d_opcode/param/size/source/sink/denied/data/corrupt/valid  in  3/3/TL_SZW/TL_AIW/1/1/TL_DW/1/1  D channel from scratchpad
- dn_d_ready  out  1
- up_d_*  out  same as dn_d_*  upstream D channel
- up_d_ready  in  1

## Operation
- Opcodes: Get = 4, PutFullData = 0, PutPartialData = 1. Beats = 2^(size-3) for size > 3, otherwise 1.
- Passthrough: a request passes unchanged as one beat, with drop tag 0, when any of the following holds:
  - size ≤ 3
  - size > MAX_SIZE
  - address is not aligned to 2^size
  - opcode is unsupported
  
  The scratchpad's error checker flags the illegal cases.
- FSM has three states: IDLE, GET_BURST, PUT_BURST.
- IDLE:
  - dn_a_* mirrors up_a_*, gated by tag-FIFO space; up_a_ready = dn_a_ready & !tag_full.
  - On acceptance of an expandable Get: latch address, size, source, param; beat counter = 1; go to GET_BURST.
  - On acceptance of an expandable Put: latch the same fields; beat counter = 1; go to PUT_BURST.
- GET_BURST:
  - up_a_ready = 0.
  - dn_a_address = base | (cnt<<3); dn_a_mask = 8'hFF; dn_a_size = latched size; opcode Get.
  - cnt increments on each dn handshake. After the handshake with cnt == beats-1, go to IDLE.
- PUT_BURST:
  - up beats forwarded combinationally with address base | (cnt<<3); size and source are taken from the latch.
  - up_a_ready = dn_a_ready & !tag_full.
  - Final beat handshake returns the FSM to IDLE.
- Tag FIFO:
  - Every dn A handshake pushes a drop bit: 1 for Put-burst beats other than the last, else 0.
  - Every dn D handshake pops one bit.
- D path:
  - Drop bit 1: dn_d_ready = 1 and up_d_valid = 0 (beat consumed silently).
  - Drop bit 0: up_d_* = dn_d_* and dn_d_ready = up_d_ready.
  - A D beat while the tag FIFO is empty is passed through.
- Simultaneous push and pop in one cycle is legal; the count is unchanged.

## Timing
- Zero-cycle combinational A forward in IDLE and PUT_BURST. Each GET_BURST beat takes one cycle when dn_a_ready=1, so an 8-beat Get is issued over 8 consecutive cycles.
- D path is combinational, zero latency.
- dn_a_valid is held stable until dn_a_ready; dn_a_* fields do not change while valid & !ready.
- Tag FIFO full (TAG_DEPTH entries): dn_a_valid = 0 and up_a_ready = 0 until a pop.
- Reset values:
  - state = IDLE; cnt = 0; latches = 0; tag FIFO empty.
  - up_a_ready follows dn_a_ready.
  - dn_a_valid = 0 and up_d_valid = 0 unless driven by inputs.
- Reset mid-burst: the burst is abandoned and the tag FIFO is cleared. Downstream must be reset together with this block.

## Configuration
- TLUL_BURST_SEQ_CHECK_EN defined: compiles SVA assertions for:
  - upstream stability while valid & !ready
  - tag FIFO overflow/underflow
  - change of up_a_opcode or up_a_source during PUT_BURST
  
  A violation raises $error.
- TLUL_BURST_SEQ_CHECK_EN not defined: no assertions; RTL behaviour is identical.

## Test plan
- Get size 3, address 0x100 -> one dn beat at 0x100 with size 3; one AccessAckData forwarded upstream.
- Get size 6, address 0x40, dn_a_ready always 1 -> 8 dn beats at 0x40..0x78 on consecutive cycles, each with size 6 and mask FF; 8 AccessAckData beats forwarded.
- PutFullData size 5, address 0x20, 4 beats -> dn addresses 0x20/0x28/0x30/0x38; 3 AccessAcks dropped; exactly 1 AccessAck upstream, carrying the original source.
- Put size 6 burst with dn_a_ready toggling 1/0 every cycle -> dn_a fields stable while stalled; beat count and address order preserved.
- Hold up_d_ready=0 with dn_a_ready=1 and 16 Get size-3 requests -> dn_a_valid drops after 16 issued; resumes as D beats drain.
- Assert rst in GET_BURST at beat 3 of 8 -> state IDLE and tag FIFO empty next cycle; no further dn beats issued.
